logic_gate_unit: RTL and testbench
==================================

Name: logic_gate_unit

Overview:
- Registered, parametrised bitwise gate block selecting one of eight logic operations per transaction.
- Successor to the single-function combinational gates.
- valid/ready handshake on both sides, two-entry output buffer, delivered-result counter.
- Sits between a stimulus/producer stage and any consumer that applies backpressure.

Parameters:
- WIDTH, 5, bit width of operands a, b and result z.
- CNT_W, 8, width of delivered-result counter.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  producer presents op/a/b.
- in_ready  output  1  unit can accept a transaction this cycle.
- op  input  3  operation select.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  z/op_out hold a valid result.
- out_ready  input  1  consumer accepts result this cycle.
- z  output  WIDTH  result.
- op_out  output  3  op code that produced z.
- count  output  CNT_W  number of results delivered.

Behaviour:
- Reset: one clock (clk); reset (rst) is asynchronous and active-high. While rst is high: buffer emptied, out_valid=0, z=0, op_out=0, count=0, in_ready=1. All outputs are forced immediately, independent of clk.
- Op encoding:
  - 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR: bitwise on a and b.
  - 110 NOT a, 111 BUF a: b ignored.
- Accept: transfer when in_valid && in_ready at rising clk. The result is computed combinationally and written into the buffer with its op.
- Buffer:
  - Two-entry FIFO; occupancy 0..2.
  - in_ready = (occupancy < 2), driven from registered occupancy only. No combinational path from out_ready to in_ready.
- Latency: a result accepted at edge N is visible on z/out_valid after edge N (1 cycle) when the buffer was empty. Otherwise it queues behind older entries.
- Output: out_valid = (occupancy > 0). z/op_out show the head entry and stay stable while out_valid && !out_ready.
- Deliver: transfer when out_valid && out_ready. The head is popped and count increments.
- count wraps modulo 2^CNT_W with no saturation or flag.
- Simultaneous push+pop, occupancy 1: occupancy stays 1; the new entry becomes head on the next cycle.
- Simultaneous push+pop, occupancy 0: not possible (out_valid=0).
- Full (occupancy 2): in_ready=0 even if out_ready=1 in that cycle. The push is refused; the pop proceeds.
- Ordering: strictly FIFO; no reordering or dropping except on reset.
- Reset mid-operation: buffered entries are discarded without delivery; count returns to 0.
- Inputs are don't-care when in_valid=0. X on op with in_valid=1 is a producer error (undefined result, no lock-up).

Optional Feature:
- Macro: LGU_PARITY_EN.
- Defined:
  - Adds output port z_par (1 bit) = XOR-reduction of z, stored with each buffer entry.
  - z_par is valid with out_valid and is 0 in reset.
- Undefined: z_par port absent; no extra storage.

Test Plan:
- Reset check: hold rst=1 with in_valid=1, a=5'b11111 -> out_valid=0, z=0, op_out=0, count=0, in_ready=1. Deassert rst -> still idle until the first accepted push.
- Single AND: op=000, a=5'b10110, b=5'b01111, out_ready=1 -> one cycle later out_valid=1, z=5'b00110, op_out=000. Next cycle count=1.
- All ops back-to-back, a=5'b11001, b=5'b10101, out_ready=1, producing z in order:
  - 000 AND -> 10001
  - 001 OR -> 11101
  - 010 XOR -> 01100
  - 011 NAND -> 01110
  - 100 NOR -> 00010
  - 101 XNOR -> 10011
  - 110 NOT a -> 00110
  - 111 BUF a -> 11001
  - Expected: one result per cycle, final count=8.
- Backpressure: out_ready=0, offer three ANDs with a=1,2,3, b=5'b11111 -> after two accepts in_ready=0 and the third is held. z holds 1 stable. Raise out_ready -> z sequence 1,2,3, no loss or duplication.
- Counter wrap (CNT_W=2): deliver 5 results -> count sequence 1,2,3,0,1.
- Reset mid-operation: two entries buffered, out_ready=0, pulse rst between clock edges -> out_valid=0 and count=0 immediately (before the next edge). After release the buffer is empty. With LGU_PARITY_EN, z=5'b10110 -> z_par=1.

Source files
------------

// File: rtl/logic_gate_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : logic_gate_unit_if
// Description : Handshake bundle for logic_gate_unit. Carries the producer
//               side (in_valid/in_ready/op/a/b), the consumer side
//               (out_valid/out_ready/z/op_out) and the delivered-result
//               counter. With LGU_PARITY_EN defined, a z_par signal is added.
//               Modports:
//                 master - producer/consumer side (drives in_valid, op, a, b,
//                          out_ready)
//                 slave  - the gate unit itself
// Revision    : 1.0 - initial release
// ============================================================================
interface logic_gate_unit_if #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic [2:0]       op_out;
  logic [CNT_W-1:0] count;
`ifdef LGU_PARITY_EN
  logic             z_par;
`endif

  modport master (
    output in_valid, op, a, b, out_ready,
`ifdef LGU_PARITY_EN
    input  z_par,
`endif
    input  in_ready, out_valid, z, op_out, count
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
`ifdef LGU_PARITY_EN
    output z_par,
`endif
    output in_ready, out_valid, z, op_out, count
  );
endinterface
`default_nettype wire

// File: rtl/logic_gate_unit.sv
`default_nettype none
// ============================================================================
// Module      : logic_gate_unit
// Description : Registered bitwise gate unit. Each accepted transaction
//               computes one of eight logic functions of a/b and pushes the
//               result and its op code into a two-entry FIFO. The FIFO head
//               is presented on z/op_out with a valid/ready handshake and
//               every delivered result increments a wrapping counter.
//               Ops: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR,
//                    110 NOT a, 111 BUF a.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-high reset
//               bus  - logic_gate_unit_if.slave (handshakes, operands,
//                      result, op_out, count)
// Options     : LGU_PARITY_EN - stores XOR-reduction of z with every entry
//                               and presents it on bus.z_par.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_gate_unit #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  logic_gate_unit_if.slave   bus
);

  localparam logic [1:0] C_OCC_FULL = 2'd2;

  // Two-entry storage, indexed by one-bit read/write pointers.
  logic [WIDTH-1:0] r_z   [0:1];
  logic [2:0]       r_op  [0:1];
`ifdef LGU_PARITY_EN
  logic             r_par [0:1];
`endif
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_occ;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_res;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;

  always_comb begin
    w_res = '0;
    case (bus.op)
      3'b000:  w_res = bus.a & bus.b;
      3'b001:  w_res = bus.a | bus.b;
      3'b010:  w_res = bus.a ^ bus.b;
      3'b011:  w_res = ~(bus.a & bus.b);
      3'b100:  w_res = ~(bus.a | bus.b);
      3'b101:  w_res = ~(bus.a ^ bus.b);
      3'b110:  w_res = ~bus.a;
      3'b111:  w_res = bus.a;
      default: w_res = '0;  // X op: result undefined, keep state sane
    endcase
  end

  // in_ready depends only on registered occupancy, so a full buffer refuses
  // a push even when the consumer pops in the same cycle.
  assign w_in_ready  = (r_occ != C_OCC_FULL);
  assign w_out_valid = (r_occ != 2'd0);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_z[0]   <= '0;
      r_z[1]   <= '0;
      r_op[0]  <= '0;
      r_op[1]  <= '0;
`ifdef LGU_PARITY_EN
      r_par[0] <= 1'b0;
      r_par[1] <= 1'b0;
`endif
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_occ    <= 2'd0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_z[r_wr_ptr]   <= w_res;
        r_op[r_wr_ptr]  <= bus.op;
`ifdef LGU_PARITY_EN
        r_par[r_wr_ptr] <= ^w_res;
`endif
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
        r_cnt    <= r_cnt + CNT_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // The head entry is driven straight from storage; reset clears storage and
  // the read pointer, so z/op_out read zero while rst is high.
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.z         = r_z[r_rd_ptr];
  assign bus.op_out    = r_op[r_rd_ptr];
  assign bus.count     = r_cnt;
`ifdef LGU_PARITY_EN
  assign bus.z_par     = r_par[r_rd_ptr];
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_gate_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_gate_unit
// Description : Directed self-checking bench for logic_gate_unit. A second
//               instance with CNT_W=2 exercises counter wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_gate_unit;

  localparam int WIDTH = 5;

  logic clk;
  logic rst;
  int   n_err;
  int   n_chk;

  logic_gate_unit_if #(.WIDTH(WIDTH), .CNT_W(8)) bus8 ();
  logic_gate_unit_if #(.WIDTH(WIDTH), .CNT_W(2)) bus2 ();

  logic_gate_unit #(.WIDTH(WIDTH), .CNT_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  logic_gate_unit #(.WIDTH(WIDTH), .CNT_W(2)) u_dut_w2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] exp_ops [0:7];

  initial begin
    n_err = 0;
    n_chk = 0;
    exp_ops[0] = 5'b10001;
    exp_ops[1] = 5'b11101;
    exp_ops[2] = 5'b01100;
    exp_ops[3] = 5'b01110;
    exp_ops[4] = 5'b00010;
    exp_ops[5] = 5'b10011;
    exp_ops[6] = 5'b00110;
    exp_ops[7] = 5'b11001;

    bus2.in_valid  = 1'b0;
    bus2.op        = 3'b000;
    bus2.a         = '0;
    bus2.b         = '0;
    bus2.out_ready = 1'b1;

    // ---------------- reset with an active producer
    rst            = 1'b1;
    bus8.in_valid  = 1'b1;
    bus8.op        = 3'b000;
    bus8.a         = 5'b11111;
    bus8.b         = 5'b11111;
    bus8.out_ready = 1'b1;
    #3;
    chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    chk("rst_z",         32'(bus8.z),         32'd0);
    chk("rst_op_out",    32'(bus8.op_out),    32'd0);
    chk("rst_count",     32'(bus8.count),     32'd0);
    chk("rst_in_ready",  32'(bus8.in_ready),  32'd1);
    step();
    step();
    chk("rst_hold_out_valid", 32'(bus8.out_valid), 32'd0);
    #2;
    bus8.in_valid = 1'b0;
    rst = 1'b0;
    step();
    chk("idle_out_valid", 32'(bus8.out_valid), 32'd0);
    chk("idle_count",     32'(bus8.count),     32'd0);

    // ---------------- single AND
    bus8.in_valid = 1'b1;
    bus8.op       = 3'b000;
    bus8.a        = 5'b10110;
    bus8.b        = 5'b01111;
    step();
    bus8.in_valid = 1'b0;
    chk("and_out_valid", 32'(bus8.out_valid), 32'd1);
    chk("and_z",         32'(bus8.z),         32'b00110);
    chk("and_op_out",    32'(bus8.op_out),    32'd0);
    step();
    chk("and_count", 32'(bus8.count),     32'd1);
    chk("and_drain", 32'(bus8.out_valid), 32'd0);

    // ---------------- all eight ops back-to-back, one result per cycle
    bus8.a = 5'b11001;
    bus8.b = 5'b10101;
    for (int i = 0; i < 8; i++) begin
      bus8.in_valid = 1'b1;
      bus8.op       = 3'(i);
      step();
      chk($sformatf("ops_valid_%0d", i), 32'(bus8.out_valid), 32'd1);
      chk($sformatf("ops_z_%0d", i),     32'(bus8.z),         32'(exp_ops[i]));
      chk($sformatf("ops_op_%0d", i),    32'(bus8.op_out),    32'(i));
      chk($sformatf("ops_cnt_%0d", i),   32'(bus8.count),     32'(1 + i));
    end
    bus8.in_valid = 1'b0;
    step();
    // one earlier delivery plus eight
    chk("ops_final_count", 32'(bus8.count), 32'd9);
    chk("ops_in_ready",    32'(bus8.in_ready), 32'd1);

    // ---------------- backpressure
    bus8.out_ready = 1'b0;
    bus8.in_valid  = 1'b1;
    bus8.op        = 3'b000;
    bus8.b         = 5'b11111;
    bus8.a         = 5'd1;
    step();
    chk("bp_in_ready_1", 32'(bus8.in_ready), 32'd1);
    chk("bp_z_1",        32'(bus8.z),        32'd1);
    bus8.a = 5'd2;
    step();
    chk("bp_in_ready_full", 32'(bus8.in_ready), 32'd0);
    chk("bp_z_hold_a",      32'(bus8.z),        32'd1);
    bus8.a = 5'd3;
    step();
    chk("bp_refused_in_ready", 32'(bus8.in_ready),  32'd0);
    chk("bp_z_hold_b",         32'(bus8.z),         32'd1);
    chk("bp_out_valid",        32'(bus8.out_valid), 32'd1);
    chk("bp_count_held",       32'(bus8.count),     32'd9);
    // full + out_ready: pop proceeds, push of 3 still refused this edge
    bus8.out_ready = 1'b1;
    step();
    chk("bp_z_2",        32'(bus8.z),        32'd2);
    chk("bp_in_ready_2", 32'(bus8.in_ready), 32'd1);
    step();
    bus8.in_valid = 1'b0;
    chk("bp_z_3", 32'(bus8.z), 32'd3);
    step();
    chk("bp_drained", 32'(bus8.out_valid), 32'd0);
    chk("bp_count",   32'(bus8.count),     32'd12);

    // ---------------- counter wrap on the CNT_W=2 instance
    bus2.op = 3'b111;
    for (int i = 0; i <= 5; i++) begin
      bus2.in_valid = (i < 5);
      bus2.a        = 5'(i + 1);
      step();
      if (i >= 1) chk($sformatf("wrap_cnt_%0d", i), 32'(bus2.count), 32'(i % 4));
    end
    bus2.in_valid = 1'b0;

    // ---------------- reset mid-operation
    bus8.out_ready = 1'b0;
    bus8.in_valid  = 1'b1;
    bus8.op        = 3'b111;
    bus8.a         = 5'b10110;
    step();
    step();
    bus8.in_valid = 1'b0;
    chk("mid_full",  32'(bus8.in_ready), 32'd0);
    chk("mid_z",     32'(bus8.z),        32'b10110);
`ifdef LGU_PARITY_EN
    chk("mid_z_par", 32'(bus8.z_par),    32'd1);
`endif
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(bus8.out_valid), 32'd0);
    chk("mid_rst_count",     32'(bus8.count),     32'd0);
    chk("mid_rst_z",         32'(bus8.z),         32'd0);
    chk("mid_rst_in_ready",  32'(bus8.in_ready),  32'd1);
`ifdef LGU_PARITY_EN
    chk("mid_rst_z_par",     32'(bus8.z_par),     32'd0);
`endif
    #2;
    rst = 1'b0;
    bus8.out_ready = 1'b1;
    step();
    chk("post_rst_empty", 32'(bus8.out_valid), 32'd0);
    chk("post_rst_count", 32'(bus8.count),     32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
